// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Continuous instruction fetch stage. Issues one memory request at
//             a time, queues {pc, instruction} pairs in a prefetch FIFO and
//             presents the FIFO head to decode. Supports redirect/flush.
//  Ports    :
//    clk_i           clock, rising edge
//    rst_i           asynchronous active-high reset
//    mem_req_o       fetch request valid
//    mem_addr_o      fetch address (stable until accepted, except on redirect)
//    mem_ready_i     memory accepts the request this cycle
//    mem_rvalid_i    read data valid
//    mem_rdata_i     instruction word
//    redirect_i      flush and restart at redirect_pc_i
//    redirect_pc_i   new PC (low two bits ignored)
//    instr_valid_o   FIFO head valid
//    instr_o         FIFO head instruction
//    instr_pc_o      FIFO head PC
//    decode_ready_i  decode consumes the head
//    fifo_count_o    occupied FIFO entries
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
   parameter int              FIFO_DEPTH = 4,
   parameter int              PC_STEP    = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   output logic                          mem_req_o,
   output logic [XLEN-1:0]               mem_addr_o,
   input  logic                          mem_ready_i,
   input  logic                          mem_rvalid_i,
   input  logic [XLEN-1:0]               mem_rdata_i,
   input  logic                          redirect_i,
   input  logic [XLEN-1:0]               redirect_pc_i,
   output logic                          instr_valid_o,
   output logic [XLEN-1:0]               instr_o,
   output logic [XLEN-1:0]               instr_pc_o,
   input  logic                          decode_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int                 C_PTR_W = $clog2(FIFO_DEPTH);
   localparam int                 C_CNT_W = C_PTR_W + 1;
   localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [XLEN-1:0]      r_fetch_pc;
   logic [XLEN-1:0]      w_fetch_pc_next;
   logic [XLEN-1:0]      r_issued_pc;
   logic                 r_discard;
   logic                 w_discard_next;
   logic [C_PTR_W-1:0]   r_rd_ptr;
   logic [C_PTR_W-1:0]   r_wr_ptr;
   logic [C_CNT_W-1:0]   r_count;
   logic [C_CNT_W-1:0]   w_count_next;
   logic [XLEN-1:0]      r_fifo_pc    [FIFO_DEPTH];
   logic [XLEN-1:0]      r_fifo_instr [FIFO_DEPTH];

   logic                 w_accept;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_valid;
   logic [XLEN-1:0]      w_redirect_pc;

   assign w_accept      = (r_state == S_REQ) && mem_ready_i;
   assign w_valid       = (r_count != '0);
   // A redirect kills both the returning response and any decode pop.
   assign w_push        = (r_state == S_WAIT) && mem_rvalid_i && !r_discard && !redirect_i;
   assign w_pop         = w_valid && decode_ready_i && !redirect_i;
   assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);

   always_comb begin
      w_count_next = r_count;
      if (redirect_i) begin
         w_count_next = '0;
      end else if (w_push && !w_pop) begin
         w_count_next = r_count + C_CNT_W'(1);
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - C_CNT_W'(1);
      end
   end

   // Next-state logic. A request is only raised when a FIFO slot is free for
   // its response, so responses never need back-pressure.
   always_comb begin
      w_state_next    = r_state;
      w_fetch_pc_next = r_fetch_pc;
      w_discard_next  = r_discard;
      case (r_state)
         S_IDLE: begin
            if (r_count < C_DEPTH) begin
               w_state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ready_i) begin
               w_state_next    = S_WAIT;
               w_fetch_pc_next = r_fetch_pc + XLEN'(PC_STEP);
            end
         end
         S_WAIT: begin
            if (mem_rvalid_i) begin
               w_discard_next = 1'b0;
               w_state_next   = (w_count_next < C_DEPTH) ? S_REQ : S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // Redirect overrides everything. If a request is (or becomes) outstanding
      // without its response this cycle, wait for it and drop it on arrival.
      if (redirect_i) begin
         w_fetch_pc_next = w_redirect_pc;
         if (w_accept || ((r_state == S_WAIT) && !mem_rvalid_i)) begin
            w_state_next   = S_WAIT;
            w_discard_next = 1'b1;
         end else begin
            w_state_next   = S_REQ;
            w_discard_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_fetch_pc  <= RESET_PC;
         r_issued_pc <= '0;
         r_discard   <= 1'b0;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_discard  <= w_discard_next;
         r_count    <= w_count_next;
         if (w_accept) begin
            r_issued_pc <= r_fetch_pc;
         end
         if (redirect_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
         end
      end
   end

   // Storage needs no reset: the head outputs are gated by the valid flag.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]    <= r_issued_pc;
         r_fifo_instr[r_wr_ptr] <= mem_rdata_i;
      end
   end

   assign mem_req_o     = (r_state == S_REQ);
   assign mem_addr_o    = r_fetch_pc;
   assign instr_valid_o = w_valid;
   assign instr_o       = w_valid ? r_fifo_instr[r_rd_ptr] : '0;
   assign instr_pc_o    = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;
   assign fifo_count_o  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: a reactive memory model
//             with configurable latency/stall, a delivery scoreboard, a
//             cycle table after reset and hand-written corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] C_RESET_PC = 32'h8000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ready_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        decode_ready_i;
   logic [2:0]  fifo_count_o;

   fetch_unit #(
      .XLEN       (32),
      .RESET_PC   (C_RESET_PC),
      .FIFO_DEPTH (4),
      .PC_STEP    (4)
   ) u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_ready_i    (mem_ready_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .instr_valid_o  (instr_valid_o),
      .instr_o        (instr_o),
      .instr_pc_o     (instr_pc_o),
      .decode_ready_i (decode_ready_i),
      .fifo_count_o   (fifo_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   typedef struct {
      logic        dec;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [2:0]  cnt;
   } vec_t;

   int          n_checks = 0;
   int          n_err    = 0;
   int          lat      = 1;
   int          stall    = 0;
   int          accepts  = 0;
   bit          pend     = 1'b0;
   bit          pend_drop = 1'b0;
   int          pend_cnt = 0;
   logic [31:0] pend_addr = '0;
   logic [31:0] exp_addr  = C_RESET_PC;
   sb_t         sb [$];
   logic [31:0] acc_q [$];
   logic [31:0] dlv_q [$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Memory model + delivery monitor. Runs 1 time unit after each falling
   // edge, after the main sequence has driven decode_ready_i/redirect_i.
   initial begin
      sb_t item;
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      forever begin
         @(negedge clk_i);
         #1;
         if (rst_i) begin
            pend         = 1'b0;
            pend_drop    = 1'b0;
            accepts      = 0;
            exp_addr     = C_RESET_PC;
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            sb.delete();
            acc_q.delete();
            dlv_q.delete();
         end else begin
            if (instr_valid_o && decode_ready_i && !redirect_i) begin
               dlv_q.push_back(instr_pc_o);
               if (sb.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL deliver_unexpected at %0t: got pc %h expected no delivery", $time, instr_pc_o);
               end else begin
                  item = sb.pop_front();
                  check("deliver_pc", instr_pc_o, item.pc);
                  check("deliver_instr", instr_o, item.instr);
               end
            end
            mem_rvalid_i = 1'b0;
            if (pend) begin
               if (pend_cnt == 1) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i  = mem_word(pend_addr);
                  if (!pend_drop && !redirect_i) begin
                     item.pc    = pend_addr;
                     item.instr = mem_word(pend_addr);
                     sb.push_back(item);
                  end
                  pend = 1'b0;
               end else begin
                  pend_cnt--;
               end
            end
            mem_ready_i = (stall == 0);
            if (stall > 0 && mem_req_o) stall--;
            if (mem_req_o && mem_ready_i) begin
               accepts++;
               acc_q.push_back(mem_addr_o);
               check("req_addr", mem_addr_o, exp_addr);
               pend      = 1'b1;
               pend_cnt  = lat;
               pend_addr = exp_addr;
               pend_drop = 1'b0;
               exp_addr  = exp_addr + 32'd4;
            end
            if (redirect_i) begin
               sb.delete();
               exp_addr = redirect_pc_i & ~32'd3;
               if (pend) pend_drop = 1'b1;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk_i);
      rst_i          = 1'b1;
      redirect_i     = 1'b0;
      decode_ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   32'(mem_req_o),     32'd0);
      check({tag, "_addr"},  mem_addr_o,         C_RESET_PC);
      check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
      check({tag, "_instr"}, instr_o,            32'd0);
      check({tag, "_pc"},    instr_pc_o,         32'd0);
      check({tag, "_count"}, 32'(fifo_count_o),  32'd0);
   endtask

   initial begin
      vec_t tbl [8];
      bit   found;

      // Cycle table after reset release: 1-cycle memory, decode always ready.
      tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         3'd0};
      tbl[1] = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0,         3'd0};
      tbl[2] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         3'd0};
      tbl[3] = '{1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000, 3'd1};
      tbl[4] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         3'd0};
      tbl[5] = '{1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004, 3'd1};
      tbl[6] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         3'd0};
      tbl[7] = '{1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0008, 3'd1};

      rst_i          = 1'b1;
      decode_ready_i = 1'b0;
      redirect_i     = 1'b0;
      redirect_pc_i  = '0;
      repeat (3) @(negedge clk_i);
      check_reset_outputs("reset");

      // Streaming with a single-cycle memory.
      lat = 1; stall = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk_i);
         decode_ready_i = tbl[i].dec;
         #2;
         check($sformatf("tbl%0d_req", i),   32'(mem_req_o),     32'(tbl[i].req));
         check($sformatf("tbl%0d_valid", i), 32'(instr_valid_o), 32'(tbl[i].valid));
         check($sformatf("tbl%0d_count", i), 32'(fifo_count_o),  32'(tbl[i].cnt));
         if (tbl[i].req)   check($sformatf("tbl%0d_addr", i), mem_addr_o, tbl[i].addr);
         if (tbl[i].valid) begin
            check($sformatf("tbl%0d_pc", i),    instr_pc_o, tbl[i].pc);
            check($sformatf("tbl%0d_instr", i), instr_o,    mem_word(tbl[i].pc));
         end
      end

      // Decode stalled: FIFO fills to depth and requests stop.
      lat = 1; stall = 0;
      do_reset();
      repeat (20) @(negedge clk_i);
      #2;
      check("fill_accepts", 32'(accepts),       32'd4);
      check("fill_count",   32'(fifo_count_o),  32'd4);
      check("fill_req",     32'(mem_req_o),     32'd0);
      check("fill_valid",   32'(instr_valid_o), 32'd1);
      check("fill_headpc",  instr_pc_o,         32'h8000_0000);
      @(negedge clk_i); decode_ready_i = 1'b1;
      @(negedge clk_i); decode_ready_i = 1'b0;
      repeat (8) @(negedge clk_i);
      #2;
      check("refill_accepts", 32'(accepts), 32'd5);
      check("refill_addr",    (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : 32'hX, 32'h8000_0010);
      check("refill_count",   32'(fifo_count_o), 32'd4);

      // Memory not ready for 3 cycles: request and address held.
      lat = 1; stall = 3;
      do_reset();
      decode_ready_i = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk_i); #2;
         check($sformatf("stall%0d_req", j),  32'(mem_req_o), 32'd1);
         check($sformatf("stall%0d_addr", j), mem_addr_o,     32'h8000_0000);
         check($sformatf("stall%0d_acc", j),  32'(accepts),   32'd0);
      end
      @(negedge clk_i); #2;
      check("stall_accept", 32'(accepts), 32'd1);
      @(negedge clk_i); #2;
      check("stall_wait_req", 32'(mem_req_o), 32'd0);
      check("stall_single",   32'(accepts),   32'd1);

      // Redirect while waiting on an outstanding response.
      lat = 3; stall = 0;
      do_reset();
      decode_ready_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h8000_0103;
      @(negedge clk_i);
      redirect_i = 1'b0;
      #2;
      check("rdw_count", 32'(fifo_count_o),  32'd0);
      check("rdw_valid", 32'(instr_valid_o), 32'd0);
      for (int k = 0; k < 40 && !instr_valid_o; k++) @(negedge clk_i);
      check("rdw_first_valid", 32'(instr_valid_o), 32'd1);
      check("rdw_first_pc",    instr_pc_o,         32'h8000_0100);
      check("rdw_first_instr", instr_o,            mem_word(32'h8000_0100));
      check("rdw_req2_addr",   (acc_q.size() > 1) ? acc_q[1] : 32'hX, 32'h8000_0100);

      // Redirect coincident with response and pop, all slots reserved.
      lat = 3; stall = 0;
      do_reset();
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_i);
         if (accepts == 4 && pend && pend_cnt == 1) begin
            found = 1'b1;
            break;
         end
      end
      check("rdr_sync",  32'(found),        32'd1);
      check("rdr_count", 32'(fifo_count_o), 32'd3);
      redirect_i     = 1'b1;
      redirect_pc_i  = 32'h8000_0200;
      decode_ready_i = 1'b1;
      @(negedge clk_i);
      redirect_i = 1'b0;
      #2;
      check("rdr_count_after", 32'(fifo_count_o),  32'd0);
      check("rdr_valid_after", 32'(instr_valid_o), 32'd0);
      check("rdr_req_after",   32'(mem_req_o),     32'd1);
      check("rdr_addr_after",  mem_addr_o,         32'h8000_0200);

      // PC wrap-around.
      @(negedge clk_i);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      dlv_q.delete();
      @(negedge clk_i);
      redirect_i = 1'b0;
      for (int k = 0; k < 60 && dlv_q.size() < 2; k++) @(negedge clk_i);
      check("wrap_pc0", (dlv_q.size() > 0) ? dlv_q[0] : 32'hX, 32'hFFFF_FFFC);
      check("wrap_pc1", (dlv_q.size() > 1) ? dlv_q[1] : 32'hX, 32'h0000_0000);

      // Asynchronous reset in the middle of a wait.
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk_i);
         if (pend && pend_cnt >= 2) begin
            found = 1'b1;
            break;
         end
      end
      check("arst_sync", 32'(found), 32'd1);
      #3;
      rst_i = 1'b1;
      #1;
      check_reset_outputs("arst");
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int k = 0; k < 40 && dlv_q.size() < 1; k++) @(negedge clk_i);
      check("arst_first_pc", (dlv_q.size() > 0) ? dlv_q[0] : 32'hX, C_RESET_PC);
      check("arst_first_req", (acc_q.size() > 0) ? acc_q[0] : 32'hX, C_RESET_PC);

      repeat (2) @(negedge clk_i);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion before 200000");
      $fatal(1);
   end

endmodule
`default_nettype wire
